// File: rtl/riscv_pkg.sv
// Shared integer-core constants and the writeback source encoding.
// Used by the writeback stage and the forwarding unit.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC  = 2'd2
  } wb_sel_e;

  // PC+4 outranks load data so a link write is never replaced by a stale mem_to_reg.
  function automatic wb_sel_e wb_sel(input logic mem_to_reg, input logic write_from_pc);
    if (write_from_pc) return WB_SEL_PC;
    if (mem_to_reg)    return WB_SEL_MEM;
    return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/wb_data_mux.sv
// 3:1 writeback value select (ALU result, load data, PC+4).
// Purely combinational; no state, no back-pressure.
module wb_data_mux
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] read_data,
  input  logic [W-1:0] pc_plus_4,
  input  logic         mem_to_reg,
  input  logic         write_from_pc,
  output logic [W-1:0] data
);

  wb_sel_e sel;

  always_comb begin
    sel  = wb_sel(mem_to_reg, write_from_pc);
    data = alu_result;
    case (sel)
      WB_SEL_PC:  data = pc_plus_4;
      WB_SEL_MEM: data = read_data;
      default:    data = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_regfile_writer.sv
// Writeback stage: selects the MEM/WB value and commits it to the integer register file.
// One write per cycle, visible in the array after one clock; reads bypass the pending write.
module wb_regfile_writer
  import riscv_pkg::*;
#(
  parameter int              XLEN    = riscv_pkg::XLEN,
  parameter int              NREGS   = riscv_pkg::NREGS,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       wb_alu_result_in,
  input  logic [XLEN-1:0]       wb_read_data_in,
  input  logic [XLEN-1:0]       wb_pc_plus_4_in,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_in,
  input  logic                  wb_reg_write_in,
  input  logic                  wb_mem_to_reg_in,
  input  logic                  wb_write_from_pc_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       wb_data_out,
  output logic                  wb_write_en_out,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  // x0 has no storage; every port decodes it to zero.
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [XLEN-1:0] sel_data;

  wb_data_mux #(.W(XLEN)) u_wb_data_mux (
    .alu_result    (wb_alu_result_in),
    .read_data     (wb_read_data_in),
    .pc_plus_4     (wb_pc_plus_4_in),
    .mem_to_reg    (wb_mem_to_reg_in),
    .write_from_pc (wb_write_from_pc_in),
    .data          (sel_data)
  );

  assign wb_data_out     = rst_n ? sel_data : '0;
  assign wb_write_en_out = wb_reg_write_in && (wb_rd_addr_in != REG_ZERO) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
      regs[REG_SP] <= SP_INIT;
    end else if (wb_write_en_out) begin
      regs[wb_rd_addr_in] <= wb_data_out;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rst_n && rs1_addr != REG_ZERO) begin
      if (wb_write_en_out && rs1_addr == wb_rd_addr_in) rs1_data = wb_data_out;
      else                                              rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rst_n && rs2_addr != REG_ZERO) begin
      if (wb_write_en_out && rs2_addr == wb_rd_addr_in) rs2_data = wb_data_out;
      else                                              rs2_data = regs[rs2_addr];
    end
  end

  assign dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Testbench for wb_regfile_writer: directed scenarios plus randomized traffic against an array model.
module tb_wb_regfile_writer;

  localparam logic [31:0] SP_INIT = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu, ld, pc4;
  logic [4:0]  rd;
  logic        rw, m2r, wfp;
  logic [4:0]  rs1, rs2, dbg_a;
  logic [31:0] rs1_data, rs2_data, wb_data, dbg_data;
  logic        we;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [32];

  wb_regfile_writer #(.SP_INIT(SP_INIT)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .wb_alu_result_in    (alu),
    .wb_read_data_in     (ld),
    .wb_pc_plus_4_in     (pc4),
    .wb_rd_addr_in       (rd),
    .wb_reg_write_in     (rw),
    .wb_mem_to_reg_in    (m2r),
    .wb_write_from_pc_in (wfp),
    .rs1_addr            (rs1),
    .rs2_addr            (rs2),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .wb_data_out         (wb_data),
    .wb_write_en_out     (we),
    .dbg_addr            (dbg_a),
    .dbg_data            (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural register array plus the spec's select/commit/read rules.
  function automatic logic [31:0] exp_sel();
    if (!rst_n) return 32'h0;
    return wfp ? pc4 : (m2r ? ld : alu);
  endfunction

  function automatic logic exp_we();
    return rst_n && rw && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'h0;
    if (exp_we() && a == rd) return exp_sel();
    return model[a];
  endfunction

  task automatic idle();
    rw = 1'b0; m2r = 1'b0; wfp = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[2] = SP_INIT;
    end else if (exp_we()) begin
      model[rd] = exp_sel();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu = $urandom; ld = $urandom; pc4 = $urandom;
    rd = 5'd4; rw = 1'b1; m2r = 1'b0; wfp = 1'b0;
    rs1 = 5'd4; rs2 = 5'd2; dbg_a = 5'd0;
    #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rs_ports: rs1=%h rs2=%h want 0", rs1_data, rs2_data);
    end
    checks++;
    if (we !== 1'b0 || wb_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_wb_outputs: we=%b data=%h want 0/0", we, wb_data);
    end
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      dbg_a = 5'(i);
      #1;
      checks++;
      if (dbg_data !== model[i]) begin
        failures++;
        $display("FAIL reset_dbg x%0d: got %h want %h", i, dbg_data, model[i]);
      end
    end
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rs_ports_late: rs1=%h rs2=%h want 0", rs1_data, rs2_data);
    end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_write();
    alu = 32'hDEAD_BEEF; rd = 5'd5; rw = 1'b1; m2r = 1'b0; wfp = 1'b0;
    rs1 = 5'd5; rs2 = 5'd2;
    #1;
    checks++;
    if (rs1_data !== 32'hDEAD_BEEF || we !== 1'b1) begin
      failures++;
      $display("FAIL alu_bypass: rs1=%h we=%b want deadbeef/1", rs1_data, we);
    end
    checks++;
    if (rs2_data !== SP_INIT) begin
      failures++;
      $display("FAIL alu_rs2_sp: got %h want %h", rs2_data, SP_INIT);
    end
    tick();
    idle();
    dbg_a = 5'd5;
    #1;
    checks++;
    if (dbg_data !== 32'hDEAD_BEEF || rs1_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL alu_commit: dbg=%h rs1=%h want deadbeef", dbg_data, rs1_data);
    end
  endtask

  task automatic test_select_priority();
    alu = 32'd1; ld = 32'd2; pc4 = 32'd3; rd = 5'd7; rw = 1'b1;
    m2r = 1'b0; wfp = 1'b0; dbg_a = 5'd7;
    #1;
    checks++;
    if (wb_data !== 32'd1) begin
      failures++;
      $display("FAIL sel_alu: got %h want 1", wb_data);
    end
    m2r = 1'b1;
    #1;
    checks++;
    if (wb_data !== 32'd2) begin
      failures++;
      $display("FAIL sel_mem: got %h want 2", wb_data);
    end
    tick();
    checks++;
    if (dbg_data !== 32'd2) begin
      failures++;
      $display("FAIL sel_mem_commit: x7=%h want 2", dbg_data);
    end
    wfp = 1'b1;
    #1;
    checks++;
    if (wb_data !== 32'd3) begin
      failures++;
      $display("FAIL sel_pc_priority: got %h want 3", wb_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (dbg_data !== 32'd3) begin
      failures++;
      $display("FAIL sel_pc_commit: x7=%h want 3", dbg_data);
    end
  endtask

  task automatic test_x0_guard();
    alu = 32'h1234; rd = 5'd0; rw = 1'b1; m2r = 1'b0; wfp = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; dbg_a = 5'd0;
    #1;
    checks++;
    if (we !== 1'b0 || rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      failures++;
      $display("FAIL x0_guard: we=%b rs1=%h rs2=%h want 0/0/0", we, rs1_data, rs2_data);
    end
    checks++;
    if (wb_data !== 32'h1234) begin
      failures++;
      $display("FAIL x0_wb_data: got %h want 1234", wb_data);
    end
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      dbg_a = 5'(i);
      #1;
      checks++;
      if (dbg_data !== model[i]) begin
        failures++;
        $display("FAIL x0_no_change x%0d: got %h want %h", i, dbg_data, model[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rs2 = 5'd9; rd = 5'd9; rw = 1'b1; m2r = 1'b0; wfp = 1'b0; alu = 32'hA;
    #1;
    checks++;
    if (rs2_data !== 32'hA) begin
      failures++;
      $display("FAIL b2b_first: rs2=%h want a", rs2_data);
    end
    tick();
    alu = 32'hB;
    #1;
    checks++;
    if (rs2_data !== 32'hB) begin
      failures++;
      $display("FAIL b2b_second: rs2=%h want b", rs2_data);
    end
    tick();
    idle();
    dbg_a = 5'd9;
    #1;
    checks++;
    if (dbg_data !== 32'hB || rs2_data !== 32'hB) begin
      failures++;
      $display("FAIL b2b_final: dbg=%h rs2=%h want b", dbg_data, rs2_data);
    end
  endtask

  task automatic test_reset_during_write();
    alu = 32'h77; rd = 5'd3; rw = 1'b1; m2r = 1'b0; wfp = 1'b0;
    tick();
    rst_n = 1'b0; alu = 32'h55; rs1 = 5'd3; rs2 = 5'd3; dbg_a = 5'd3;
    #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0 || we !== 1'b0 || wb_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_write_ports: rs1=%h rs2=%h we=%b wb=%h want 0", rs1_data, rs2_data, we, wb_data);
    end
    checks++;
    if (dbg_data !== 32'h77) begin
      failures++;
      $display("FAIL rst_dbg_visible: x3=%h want 77", dbg_data);
    end
    tick();
    checks++;
    if (dbg_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_write_dropped: x3=%h want 0", dbg_data);
    end
    dbg_a = 5'd2;
    #1;
    checks++;
    if (dbg_data !== SP_INIT) begin
      failures++;
      $display("FAIL rst_sp_reload: x2=%h want %h", dbg_data, SP_INIT);
    end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      alu = $urandom; ld = $urandom; pc4 = $urandom;
      rd  = 5'($urandom_range(0, 31));
      rw  = ($urandom_range(0, 3) != 0);
      m2r = $urandom_range(0, 1) != 0;
      wfp = $urandom_range(0, 3) == 0;
      rs1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      dbg_a = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (rs1_data !== exp_read(rs1) || rs2_data !== exp_read(rs2)) begin
        failures++;
        $display("FAIL rand_read[%0d]: rs1(%0d)=%h/%h rs2(%0d)=%h/%h", n, rs1, rs1_data,
                 exp_read(rs1), rs2, rs2_data, exp_read(rs2));
      end
      checks++;
      if (wb_data !== exp_sel() || we !== exp_we()) begin
        failures++;
        $display("FAIL rand_wb[%0d]: data=%h we=%b want %h/%b", n, wb_data, we, exp_sel(), exp_we());
      end
      checks++;
      if (dbg_data !== model[dbg_a]) begin
        failures++;
        $display("FAIL rand_dbg[%0d]: x%0d=%h want %h", n, dbg_a, dbg_data, model[dbg_a]);
      end
      tick();
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    alu = '0; ld = '0; pc4 = '0; rd = '0; rs1 = '0; rs2 = '0; dbg_a = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_alu_write();
    test_select_priority();
    test_x0_guard();
    test_back_to_back();
    test_reset_during_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
